// File: rtl/count_seg_scan_pkg.sv
// Shared types and constants for the two-digit multiplexed 7-segment scanner.
package count_seg_pkg;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_W  = 2;

  typedef enum logic {
    ST_ONES = 1'b0,
    ST_TENS = 1'b1
  } scan_state_e;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high
  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  localparam logic [AN_W-1:0] AN_ONES = 2'b01;
  localparam logic [AN_W-1:0] AN_TENS = 2'b10;

endpackage

// File: rtl/count_seg_scan_if.sv
// Count input and display-pin bundle between counter, scanner and board pins.
interface count_seg_scan_if;
  import count_seg_pkg::*;

  logic [CNT_W-1:0] cnt_in;
  logic             freeze;
  logic [SEG_W-1:0] seg;
  logic [AN_W-1:0]  an;
  logic             frame_done;

  modport master (output cnt_in, freeze, input seg, an, frame_done);
  modport slave  (input cnt_in, freeze, output seg, an, frame_done);

endinterface

// File: rtl/count_seg_scan_decode.sv
// Combinational BCD digit to 7-segment pattern; non-decimal codes blank.
module seg7_decode
  import count_seg_pkg::*;
(
  input  logic [CNT_W-1:0] digit,
  output logic [SEG_W-1:0] pattern_c
);

  always_comb begin
    pattern_c = SEG_BLANK;
    case (digit)
      4'd0:    pattern_c = SEG_0;
      4'd1:    pattern_c = SEG_1;
      4'd2:    pattern_c = SEG_2;
      4'd3:    pattern_c = SEG_3;
      4'd4:    pattern_c = SEG_4;
      4'd5:    pattern_c = SEG_5;
      4'd6:    pattern_c = SEG_6;
      4'd7:    pattern_c = SEG_7;
      4'd8:    pattern_c = SEG_8;
      4'd9:    pattern_c = SEG_9;
      default: pattern_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_seg_scan.sv
// Snapshots the 4-bit count once per frame and scans it out as two decimal
// digits on a multiplexed 7-segment display.
module count_seg_scan
  import count_seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV    = 4,
  parameter bit          BLANK_LZ       = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  count_seg_scan_if.slave  bus
);

  localparam int unsigned DIV_W = $clog2(REFRESH_DIV);

  logic [DIV_W-1:0] div;
  scan_state_e      state;
  logic [CNT_W-1:0] shadow;
  logic [SEG_W-1:0] seg_q;
  logic [AN_W-1:0]  an_q;
  logic             frame_done_q;

  logic             tick;
  logic             boundary;
  logic             over_nine;
  logic [CNT_W-1:0] tens;
  logic [CNT_W-1:0] ones;
  logic [CNT_W-1:0] digit;
  logic [SEG_W-1:0] pattern_c;
  logic [SEG_W-1:0] seg_d;
  logic [AN_W-1:0]  an_d;

  assign tick     = (div == DIV_W'(REFRESH_DIV - 1));
  assign boundary = tick && (state == ST_TENS);

  // Count is at most 15, so the tens digit is only ever 0 or 1
  assign over_nine = (shadow >= CNT_W'(10));
  assign tens      = over_nine ? CNT_W'(1) : CNT_W'(0);
  assign ones      = over_nine ? (shadow - CNT_W'(10)) : shadow;

  always_comb begin
    digit = ones;
    an_d  = AN_ONES;
    if (state == ST_TENS) begin
      digit = tens;
      an_d  = AN_TENS;
    end
  end

  seg7_decode u_decode (
    .digit     (digit),
    .pattern_c (pattern_c)
  );

  always_comb begin
    seg_d = pattern_c;
    if ((state == ST_TENS) && BLANK_LZ && !over_nine) begin
      seg_d = SEG_BLANK;
    end
  end

  // Divider, scan FSM and per-frame snapshot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div          <= '0;
      state        <= ST_ONES;
      shadow       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      div          <= tick ? '0 : (div + DIV_W'(1));
      frame_done_q <= boundary && !bus.freeze;
      if (tick) begin
        state <= (state == ST_ONES) ? ST_TENS : ST_ONES;
      end
      if (boundary && !bus.freeze) begin
        shadow <= bus.cnt_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q <= SEG_BLANK;
      an_q  <= '0;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  // Pin polarity applied after the register, so it covers the reset value too
  assign bus.seg        = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign bus.an         = SEG_ACTIVE_LOW ? ~an_q  : an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: doc/count_seg_scan.md
Name: count_seg_scan

Overview:
- Downstream consumer of the 4-bit free-running counter output.
- Displays the count (0-15) as two decimal digits on a multiplexed two-digit common-anode-select 7-segment display.
- Holds a per-frame snapshot of the count so the digits never tear, and scans the digits with a refresh divider.
- Sits between the counter and the board display pins.

Parameters:
- REFRESH_DIV, 4, clock cycles each digit is held. Must be ≥2. Use 4 in sim, larger on board.
- BLANK_LZ, 1, 1 = blank the tens digit when it is 0.
- SEG_ACTIVE_LOW, 0, 1 = invert seg and an outputs at the pins.

Ports:
- clk  input  1  system clock, all logic rising-edge
- rst  input  1  asynchronous, active-low reset
- cnt_in  input  4  count value from counter stage
- freeze  input  1  1 = keep the current snapshot and do not resample cnt_in
- seg  output  7  segments {g,f,e,d,c,b,a}, registered
- an  output  2  digit enables {tens,ones}, one-hot, registered
- frame_done  output  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset (rst=0, async): div=0, state=ONES, shadow=0, seg=7'h00, an=2'b00, frame_done=0. All values are pre-inversion.
- div counts 0..REFRESH_DIV-1 and wraps. tick=(div==REFRESH_DIV-1).
- FSM, two states with ONES as the encoding of the first state:
  - ONES→TENS on tick.
  - TENS→ONES on tick; this is the frame boundary.
  - No other transitions.
- Frame boundary (tick in TENS):
  - If freeze=0: shadow<=cnt_in and frame_done<=1 for exactly one cycle.
  - If freeze=1: shadow holds and frame_done stays 0.
- Frame period is 2*REFRESH_DIV cycles.
- BCD split of shadow, combinational:
  - tens = (shadow≥10) ? 1 : 0
  - ones = (shadow≥10) ? shadow-10 : shadow
- Output register, updated every cycle from the current state and shadow (1-cycle latency):
  - ONES: an=2'b01, seg=decode(ones).
  - TENS: an=2'b10, seg = (BLANK_LZ && tens==0) ? 7'h00 : decode(tens).
- Decode patterns (gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. Other codes →7'h00, which is unreachable.
- SEG_ACTIVE_LOW=1 inverts seg and an after the register. This includes the reset value, so the pins read all-ones during reset.
- First cycle after reset release: an=01, seg=3F (shows "0").
- cnt_in changing mid-frame has no effect until the next frame boundary.
- cnt_in wrap 15→0 is displayed as "15" then "0", with tens blanked per BLANK_LZ.
- freeze asserted exactly on the boundary cycle blocks that snapshot.
- Reset asserted mid-frame immediately forces the reset values. Scanning restarts from ONES with div=0.

Decomposition:
- Package count_seg_pkg holds:
  - state encodings (ST_ONES, ST_TENS)
  - the 7-segment pattern constants SEG_0..SEG_9 and SEG_BLANK
  - AN_ONES and AN_TENS
- One natural sub-module: seg7_decode, combinational, 4-bit in → 7-bit pattern. It is instantiated once on the muxed digit.
- Top holds the divider, FSM, shadow, BCD split and output registers.

Test Plan (REFRESH_DIV=4, BLANK_LZ=1, SEG_ACTIVE_LOW=0):
1. Reset held 3 cycles, then released with cnt_in=0 → during reset seg=00, an=00. Cycle 1 after release: an=01, seg=3F. an toggles every 4 cycles. The tens phase shows seg=00 (blanked).
2. cnt_in=7 applied mid-frame → the display stays "0" until the boundary. frame_done pulses once at cycle 8. Next frame: ones phase seg=07, tens phase seg=00.
3. cnt_in=13 → after the boundary: ones phase seg=4F (3), tens phase an=10 with seg=06 (1).
4. freeze=1 while cnt_in steps 13→14→15 across 3 frames → the display holds "13" and frame_done stays 0. freeze=0 → the next boundary shows "15" (ones=6D, tens=06).
5. rst pulled low for 1 cycle during the TENS phase → outputs go to 00/00 asynchronously. Scanning resumes from ONES with div=0 and the display shows "0".
6. Rerun with SEG_ACTIVE_LOW=1 and BLANK_LZ=0, cnt_in=5 → during reset seg=7F, an=11. After the boundary: ones phase seg=~6D=12, an=10. Tens phase seg=~3F=40, an=01.
